// File: rtl/multicart_pkg.sv
// Shared types and constants for the multicart mapper.
// The optional NVRAM window is selected by defining MULTICART_NVRAM_EN.
package multicart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_COMMIT = 2'd2
  } rst_state_t;

  typedef enum logic [1:0] {
    TAG_PASS  = 2'b00,
    TAG_ROM   = 2'b01,
    TAG_RAM   = 2'b10,
    TAG_NVRAM = 2'b11
  } region_tag_t;

  localparam logic [7:0] OFF_GLOBAL = 8'hF0;
  localparam logic [7:0] OFF_RESET  = 8'hFF;
  localparam logic [7:0] RESET_KEY  = 8'hA5;

endpackage

// File: rtl/multicart_reset_seq.sv
// Soft-reset sequencer: IDLE -> PULSE (RST_CYCLES) -> COMMIT -> IDLE.
// All outputs are registered; o_commit is high for the single COMMIT cycle.
module multicart_reset_seq
  import multicart_pkg::*;
#(
  parameter int RST_CYCLES = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_trigger,
  output logic o_soft_reset,
  output logic o_busy,
  output logic o_commit
);

  rst_state_t r_state;
  logic [7:0] r_cnt;
  logic       r_soft, r_busy, r_commit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_soft   <= 1'b0;
      r_busy   <= 1'b0;
      r_commit <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_trigger) begin
          r_state <= ST_PULSE;
          r_cnt   <= 8'(RST_CYCLES - 1);
          r_soft  <= 1'b1;
          r_busy  <= 1'b1;
        end
        ST_PULSE: if (r_cnt == 8'd0) begin
          r_state  <= ST_COMMIT;
          r_soft   <= 1'b0;
          r_commit <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 8'd1;
        end
        ST_COMMIT: begin
          r_state  <= ST_IDLE;
          r_commit <= 1'b0;
          r_busy   <= 1'b0;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_soft   <= 1'b0;
          r_busy   <= 1'b0;
          r_commit <= 1'b0;
        end
      endcase
    end
  end

  assign o_soft_reset = r_soft;
  assign o_busy       = r_busy;
  assign o_commit     = r_commit;

endmodule

// File: rtl/multicart_mapper.sv
// Cartridge bank mapper: per-window shadow/live bank registers, boot mode, soft-reset commit.
// Define MULTICART_NVRAM_EN to add the NVRAM window on ram123/io2/io3 with dirty tracking.
module multicart_mapper
  import multicart_pkg::*;
#(
  parameter int               NUM_WIN    = 4,
  parameter int               BANK_W     = 8,
  parameter int               RST_CYCLES = 32,
  parameter logic [BANK_W-1:0] BOOT_BANK = '1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               active,
  input  logic               vic_strobe,
  input  logic [15:0]        vic_addr,
  input  logic               vic_wr_n,
  input  logic               vic_io2_sel,
  input  logic               vic_io3_sel,
  input  logic               vic_ram123_sel,
  input  logic [NUM_WIN-1:0] vic_win_sel,
  input  logic [7:0]         from_vic,
  output logic [7:0]         to_vic,
  output logic               mc_qm,
  output logic [BANK_W+14:0] mc_addr,
  output logic               mc_wr_n,
  output logic               mc_sdram_en,
  output logic               mc_soft_reset,
  output logic               mc_busy,
  output logic               mc_nvram_sel,
  output logic               nvram_dirty,
  input  logic               nvram_dirty_clr
);

  localparam int AW = BANK_W + 15;

  logic [7:0] w_off;
  logic       w_busy, w_commit, w_trigger, w_reg_wr, w_rd;
  logic       w_nv_sel, w_nv_en;
  logic       r_bank_ena;

  logic [NUM_WIN-1:0][BANK_W-1:0] w_lv_bank;
  logic [NUM_WIN-1:0]             w_lv_ram, w_lv_wp;
  logic [NUM_WIN-1:0][7:0]        w_rd_lo, w_rd_ctl;

  assign w_off     = vic_addr[7:0];
  assign w_reg_wr  = vic_strobe && vic_io3_sel && !vic_wr_n && !w_busy;
  assign w_rd      = vic_strobe && vic_io3_sel && vic_wr_n;
  assign w_trigger = w_reg_wr && (w_off == OFF_RESET) && (from_vic == RESET_KEY);

  multicart_reset_seq #(.RST_CYCLES(RST_CYCLES)) u_seq (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_trigger    (w_trigger),
    .o_soft_reset (mc_soft_reset),
    .o_busy       (w_busy),
    .o_commit     (w_commit)
  );
  assign mc_busy = w_busy;

  for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_win
    logic [BANK_W-1:0] r_sh_bank, r_lv_bank, w_nxt_bank;
    logic              r_sh_ram, r_sh_wp, r_lv_ram, r_lv_wp;
    logic              w_wr_lo, w_wr_ctl, w_nxt_ram, w_nxt_wp;
    logic [13:0]       w_cur;

    assign w_wr_lo   = w_reg_wr && (w_off == 8'(2*gi));
    assign w_wr_ctl  = w_reg_wr && (w_off == 8'(2*gi + 1));
    assign w_cur     = 14'(r_sh_bank);
    // Bank bits above 7 live in the low bits of the control byte.
    assign w_nxt_bank = w_wr_lo  ? BANK_W'({w_cur[13:8], from_vic}) :
                        w_wr_ctl ? BANK_W'({from_vic[5:0], w_cur[7:0]}) : r_sh_bank;
    assign w_nxt_ram = w_wr_ctl ? from_vic[7] : r_sh_ram;
    assign w_nxt_wp  = w_wr_ctl ? from_vic[6] : r_sh_wp;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_sh_bank <= '0;
        r_sh_ram  <= 1'b0;
        r_sh_wp   <= 1'b0;
        r_lv_bank <= '0;
        r_lv_ram  <= 1'b0;
        r_lv_wp   <= 1'b0;
      end else if (w_wr_lo || w_wr_ctl) begin
        r_sh_bank <= w_nxt_bank;
        r_sh_ram  <= w_nxt_ram;
        r_sh_wp   <= w_nxt_wp;
        if (r_bank_ena) begin
          r_lv_bank <= w_nxt_bank;
          r_lv_ram  <= w_nxt_ram;
          r_lv_wp   <= w_nxt_wp;
        end
      end else if (w_commit) begin
        r_lv_bank <= r_sh_bank;
        r_lv_ram  <= r_sh_ram;
        r_lv_wp   <= r_sh_wp;
      end
    end

    assign w_lv_bank[gi] = r_lv_bank;
    assign w_lv_ram[gi]  = r_lv_ram;
    assign w_lv_wp[gi]   = r_lv_wp;
    assign w_rd_lo[gi]   = w_cur[7:0];
    assign w_rd_ctl[gi]  = {r_sh_ram, r_sh_wp, w_cur[13:8]};
  end

`ifdef MULTICART_NVRAM_EN
  logic r_nv_en, r_nv_dirty;

  assign w_nv_en  = r_nv_en;
  assign w_nv_sel = active && r_nv_en && (vic_ram123_sel || vic_io2_sel || vic_io3_sel);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_nv_en    <= 1'b0;
      r_nv_dirty <= 1'b0;
    end else begin
      if (w_reg_wr && (w_off == OFF_GLOBAL)) r_nv_en <= from_vic[0];
      if (vic_strobe && !vic_wr_n && w_nv_sel) r_nv_dirty <= 1'b1;
      else if (nvram_dirty_clr)                r_nv_dirty <= 1'b0;
    end
  end

  assign mc_nvram_sel = w_nv_sel;
  assign nvram_dirty  = r_nv_dirty;
`else
  logic w_unused;

  assign w_unused     = &{1'b0, nvram_dirty_clr, vic_io2_sel, vic_ram123_sel};
  assign w_nv_en      = 1'b0;
  assign w_nv_sel     = 1'b0;
  assign mc_nvram_sel = 1'b0;
  assign nvram_dirty  = 1'b0;
`endif

  // Register readback returns shadow values, so software sees what it wrote before commit.
  logic       w_rd_hit;
  logic [7:0] w_rd_data;

  always_comb begin
    w_rd_hit  = 1'b0;
    w_rd_data = '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      if (w_off == 8'(2*i))     begin w_rd_hit = 1'b1; w_rd_data = w_rd_lo[i];  end
      if (w_off == 8'(2*i + 1)) begin w_rd_hit = 1'b1; w_rd_data = w_rd_ctl[i]; end
    end
    if (w_off == OFF_GLOBAL) begin
      w_rd_hit  = 1'b1;
      w_rd_data = {7'd0, w_nv_en};
    end
  end

  logic [7:0] r_to_vic;
  logic       r_qm;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_vic   <= '0;
      r_qm       <= 1'b0;
      r_bank_ena <= 1'b0;
    end else begin
      r_qm       <= w_rd && w_rd_hit;
      r_to_vic   <= (w_rd && w_rd_hit) ? w_rd_data : 8'd0;
      if (w_commit) r_bank_ena <= 1'b1;
    end
  end

  assign to_vic = r_to_vic;
  assign mc_qm  = r_qm;

  logic              w_win_hit, w_win_ram, w_win_wp;
  logic [BANK_W-1:0] w_win_bank;

  always_comb begin
    w_win_hit  = 1'b0;
    w_win_bank = '0;
    w_win_ram  = 1'b0;
    w_win_wp   = 1'b0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (vic_win_sel[i]) begin
        w_win_hit  = 1'b1;
        w_win_bank = w_lv_bank[i];
        w_win_ram  = w_lv_ram[i];
        w_win_wp   = w_lv_wp[i];
      end
    end

    mc_addr = {TAG_PASS, (AW-2)'(vic_addr)};
    mc_wr_n = vic_wr_n;
    if (active && w_nv_sel) begin
      mc_addr = {TAG_NVRAM, (AW-2)'(vic_addr)};
    end else if (active && w_win_hit) begin
      if (!r_bank_ena) begin
        mc_addr = {TAG_ROM, BOOT_BANK, vic_addr[12:0]};
        mc_wr_n = 1'b1;
      end else begin
        mc_addr = {(w_win_ram ? TAG_RAM : TAG_ROM), w_win_bank, vic_addr[12:0]};
        mc_wr_n = vic_wr_n || !w_win_ram || w_win_wp;
      end
    end
  end

  assign mc_sdram_en = (|vic_win_sel) || w_nv_sel;

endmodule

// File: tb/tb_multicart_mapper.sv
// Directed bench for multicart_mapper; NVRAM expectations follow MULTICART_NVRAM_EN.
module tb_multicart_mapper;

`ifdef MULTICART_NVRAM_EN
  localparam bit NV = 1'b1;
`else
  localparam bit NV = 1'b0;
`endif

  logic        clk = 1'b0, reset_n = 1'b0, active = 1'b0;
  logic        vic_strobe = 1'b0, vic_wr_n = 1'b1;
  logic        vic_io2_sel = 1'b0, vic_io3_sel = 1'b0, vic_ram123_sel = 1'b0;
  logic [15:0] vic_addr = 16'h0;
  logic [3:0]  vic_win_sel = 4'h0;
  logic [7:0]  from_vic = 8'h0;
  logic        nvram_dirty_clr = 1'b0;

  logic [7:0]  to_vic;
  logic        mc_qm, mc_wr_n, mc_sdram_en, mc_soft_reset, mc_busy, mc_nvram_sel, nvram_dirty;
  logic [22:0] mc_addr;

  int vec = 0, miss = 0;

  always #5 clk = ~clk;

  multicart_mapper dut (
    .clk(clk), .reset_n(reset_n), .active(active), .vic_strobe(vic_strobe),
    .vic_addr(vic_addr), .vic_wr_n(vic_wr_n), .vic_io2_sel(vic_io2_sel),
    .vic_io3_sel(vic_io3_sel), .vic_ram123_sel(vic_ram123_sel), .vic_win_sel(vic_win_sel),
    .from_vic(from_vic), .to_vic(to_vic), .mc_qm(mc_qm), .mc_addr(mc_addr),
    .mc_wr_n(mc_wr_n), .mc_sdram_en(mc_sdram_en), .mc_soft_reset(mc_soft_reset),
    .mc_busy(mc_busy), .mc_nvram_sel(mc_nvram_sel), .nvram_dirty(nvram_dirty),
    .nvram_dirty_clr(nvram_dirty_clr)
  );

  task automatic idle_bus();
    vic_strobe = 1'b0; vic_wr_n = 1'b1; vic_io2_sel = 1'b0; vic_io3_sel = 1'b0;
    vic_ram123_sel = 1'b0; vic_win_sel = 4'h0; nvram_dirty_clr = 1'b0;
  endtask

  task automatic reg_write(input logic [7:0] off, input logic [7:0] d);
    @(posedge clk); #1;
    vic_strobe = 1'b1; vic_io3_sel = 1'b1; vic_wr_n = 1'b0;
    vic_addr = {8'hDF, off}; from_vic = d;
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic reg_read(input logic [7:0] off);
    @(posedge clk); #1;
    vic_strobe = 1'b1; vic_io3_sel = 1'b1; vic_wr_n = 1'b1; vic_addr = {8'hDF, off};
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (mc_soft_reset !== 1'b0) begin miss++; $display("FAIL rst_soft got %b exp 0", mc_soft_reset); end
    vec++; if (mc_busy !== 1'b0)       begin miss++; $display("FAIL rst_busy got %b exp 0", mc_busy); end
    vec++; if (mc_qm !== 1'b0)         begin miss++; $display("FAIL rst_qm got %b exp 0", mc_qm); end
    vec++; if (to_vic !== 8'h00)       begin miss++; $display("FAIL rst_to_vic got %h exp 00", to_vic); end
    vec++; if (nvram_dirty !== 1'b0)   begin miss++; $display("FAIL rst_dirty got %b exp 0", nvram_dirty); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_boot_map();
    logic [22:0] exp;
    @(posedge clk); #1;
    active = 1'b1; vic_win_sel = 4'b1000; vic_addr = 16'hA123; vic_wr_n = 1'b0;
    #1;
    exp = {2'b01, 8'hFF, 13'h0123};
    vec++; if (mc_addr !== exp)     begin miss++; $display("FAIL boot_blk5 got %h exp %h", mc_addr, exp); end
    vec++; if (mc_wr_n !== 1'b1)    begin miss++; $display("FAIL boot_wr_n got %b exp 1", mc_wr_n); end
    vec++; if (mc_sdram_en !== 1'b1) begin miss++; $display("FAIL boot_sdram got %b exp 1", mc_sdram_en); end
    vic_win_sel = 4'b0000; vic_addr = 16'h1234;
    #1;
    vec++; if (mc_addr !== 23'h001234) begin miss++; $display("FAIL nowin_addr got %h exp 001234", mc_addr); end
    vec++; if (mc_wr_n !== 1'b0)       begin miss++; $display("FAIL nowin_wr_n got %b exp 0", mc_wr_n); end
    idle_bus();
  endtask

  task automatic test_inactive();
    @(posedge clk); #1;
    active = 1'b0; vic_win_sel = 4'b0001; vic_addr = 16'h2345; vic_wr_n = 1'b0;
    #1;
    vec++; if (mc_addr !== 23'h002345) begin miss++; $display("FAIL inact_addr got %h exp 002345", mc_addr); end
    vec++; if (mc_wr_n !== 1'b0)       begin miss++; $display("FAIL inact_wr_n got %b exp 0", mc_wr_n); end
    idle_bus(); active = 1'b1;
  endtask

  task automatic test_regs_boot();
    logic [22:0] exp;
    reg_write(8'h00, 8'h12);
    reg_read(8'h00);
    vec++; if (to_vic !== 8'h12) begin miss++; $display("FAIL rd_bank0 got %h exp 12", to_vic); end
    vec++; if (mc_qm !== 1'b1)   begin miss++; $display("FAIL rd_qm got %b exp 1", mc_qm); end
    @(posedge clk); #1;
    vec++; if (mc_qm !== 1'b0)   begin miss++; $display("FAIL qm_drop got %b exp 0", mc_qm); end
    vic_win_sel = 4'b0001; vic_addr = 16'h2010;
    #1;
    exp = {2'b01, 8'hFF, 13'h0010};
    vec++; if (mc_addr !== exp) begin miss++; $display("FAIL boot_win0 got %h exp %h", mc_addr, exp); end
    idle_bus();
    reg_write(8'h08, 8'h77);
    reg_read(8'h08);
    vec++; if (mc_qm !== 1'b0) begin miss++; $display("FAIL rd_unmapped8 got %b exp 0", mc_qm); end
    reg_read(8'hFF);
    vec++; if (mc_qm !== 1'b0) begin miss++; $display("FAIL rd_trigger got %b exp 0", mc_qm); end
  endtask

  task automatic test_bad_key();
    reg_write(8'hFF, 8'h5A);
    repeat (3) @(posedge clk);
    #1;
    vec++; if (mc_soft_reset !== 1'b0) begin miss++; $display("FAIL badkey_soft got %b exp 0", mc_soft_reset); end
    vec++; if (mc_busy !== 1'b0)       begin miss++; $display("FAIL badkey_busy got %b exp 0", mc_busy); end
  endtask

  task automatic test_soft_reset();
    int n;
    logic [22:0] exp;
    reg_write(8'hFF, 8'hA5);
    vec++; if (mc_soft_reset !== 1'b1) begin miss++; $display("FAIL pulse_start got %b exp 1", mc_soft_reset); end
    vec++; if (mc_busy !== 1'b1)       begin miss++; $display("FAIL busy_start got %b exp 1", mc_busy); end
    n = 0;
    for (int c = 0; c < 100 && mc_soft_reset; c++) begin
      if (c == 5) begin
        vic_strobe = 1'b1; vic_io3_sel = 1'b1; vic_wr_n = 1'b0; vic_addr = 16'hDFFF; from_vic = 8'hA5;
      end
      if (c == 8) begin
        vic_strobe = 1'b1; vic_io3_sel = 1'b1; vic_wr_n = 1'b0; vic_addr = 16'hDF00; from_vic = 8'h34;
      end
      @(posedge clk); #1;
      idle_bus();
      n++;
    end
    vec++; if (n !== 32)        begin miss++; $display("FAIL pulse_len got %0d exp 32", n); end
    vec++; if (mc_busy !== 1'b1) begin miss++; $display("FAIL commit_busy got %b exp 1", mc_busy); end
    @(posedge clk); #1;
    vec++; if (mc_busy !== 1'b0) begin miss++; $display("FAIL idle_busy got %b exp 0", mc_busy); end
    vic_win_sel = 4'b0001; vic_addr = 16'h2010;
    #1;
    exp = {2'b01, 8'h12, 13'h0010};
    vec++; if (mc_addr !== exp) begin miss++; $display("FAIL commit_map got %h exp %h", mc_addr, exp); end
    idle_bus();
    reg_read(8'h00);
    vec++; if (to_vic !== 8'h12) begin miss++; $display("FAIL drop_busy_wr got %h exp 12", to_vic); end
    repeat (40) @(posedge clk);
    #1;
    vec++; if (mc_soft_reset !== 1'b0) begin miss++; $display("FAIL second_trig got %b exp 0", mc_soft_reset); end
  endtask

  task automatic test_write_protect();
    logic [22:0] exp;
    reg_write(8'h02, 8'h05);
    reg_write(8'h03, 8'hC0);
    vic_win_sel = 4'b0010; vic_addr = 16'h4000; vic_wr_n = 1'b0;
    #1;
    exp = {2'b10, 8'h05, 13'h0000};
    vec++; if (mc_addr !== exp)  begin miss++; $display("FAIL ram_addr got %h exp %h", mc_addr, exp); end
    vec++; if (mc_wr_n !== 1'b1) begin miss++; $display("FAIL wp_wr_n got %b exp 1", mc_wr_n); end
    idle_bus();
    reg_write(8'h03, 8'h80);
    vic_win_sel = 4'b0010; vic_addr = 16'h4000; vic_wr_n = 1'b0;
    #1;
    vec++; if (mc_wr_n !== 1'b0) begin miss++; $display("FAIL ram_wr_n got %b exp 0", mc_wr_n); end
    vic_win_sel = 4'b0001; vic_addr = 16'h2000;
    #1;
    vec++; if (mc_wr_n !== 1'b1) begin miss++; $display("FAIL rom_wr_n got %b exp 1", mc_wr_n); end
    idle_bus();
    reg_write(8'h00, 8'h56);
    vic_win_sel = 4'b0001; vic_addr = 16'h3FFF;
    #1;
    exp = {2'b01, 8'h56, 13'h1FFF};
    vec++; if (mc_addr !== exp) begin miss++; $display("FAIL live_upd got %h exp %h", mc_addr, exp); end
    idle_bus();
    reg_read(8'h03);
    vec++; if (to_vic !== 8'h80) begin miss++; $display("FAIL rd_ctl1 got %h exp 80", to_vic); end
  endtask

  task automatic test_nvram();
    logic [22:0] exp;
    reg_write(8'hF0, 8'h01);
    reg_read(8'hF0);
    vec++; if (to_vic !== (NV ? 8'h01 : 8'h00)) begin miss++; $display("FAIL rd_global got %h exp %h", to_vic, NV ? 8'h01 : 8'h00); end
    @(posedge clk); #1;
    vic_strobe = 1'b1; vic_ram123_sel = 1'b1; vic_wr_n = 1'b0; vic_addr = 16'h0400; nvram_dirty_clr = 1'b1;
    #1;
    exp = NV ? 23'h600400 : 23'h000400;
    vec++; if (mc_addr !== exp)        begin miss++; $display("FAIL nv_addr got %h exp %h", mc_addr, exp); end
    vec++; if (mc_nvram_sel !== NV)    begin miss++; $display("FAIL nv_sel got %b exp %b", mc_nvram_sel, NV); end
    vec++; if (mc_sdram_en !== NV)     begin miss++; $display("FAIL nv_sdram got %b exp %b", mc_sdram_en, NV); end
    @(posedge clk); #1;
    idle_bus();
    vec++; if (nvram_dirty !== NV)     begin miss++; $display("FAIL dirty_set got %b exp %b", nvram_dirty, NV); end
    nvram_dirty_clr = 1'b1;
    @(posedge clk); #1;
    nvram_dirty_clr = 1'b0;
    vec++; if (nvram_dirty !== 1'b0)   begin miss++; $display("FAIL dirty_clr got %b exp 0", nvram_dirty); end
  endtask

  task automatic test_reset_mid_pulse();
    logic [22:0] exp;
    bit seen;
    reg_write(8'h00, 8'h99);
    reg_write(8'hFF, 8'hA5);
    repeat (5) @(posedge clk);
    #1;
    vec++; if (mc_soft_reset !== 1'b1) begin miss++; $display("FAIL mid_pulse got %b exp 1", mc_soft_reset); end
    reset_n = 1'b0;
    #1;
    vec++; if (mc_soft_reset !== 1'b0) begin miss++; $display("FAIL async_soft got %b exp 0", mc_soft_reset); end
    vec++; if (mc_busy !== 1'b0)       begin miss++; $display("FAIL async_busy got %b exp 0", mc_busy); end
    vic_win_sel = 4'b0001; vic_addr = 16'h2010;
    #1;
    exp = {2'b01, 8'hFF, 13'h0010};
    vec++; if (mc_addr !== exp) begin miss++; $display("FAIL rst_boot_map got %h exp %h", mc_addr, exp); end
    idle_bus();
    @(negedge clk); reset_n = 1'b1;
    reg_read(8'h00);
    vec++; if (to_vic !== 8'h00) begin miss++; $display("FAIL rst_shadow got %h exp 00", to_vic); end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (mc_soft_reset || mc_busy) seen = 1'b1;
    end
    vec++; if (seen !== 1'b0) begin miss++; $display("FAIL no_resume got %b exp 0", seen); end
  endtask

  initial begin
    test_reset();
    test_boot_map();
    test_inactive();
    test_regs_boot();
    test_bad_key();
    test_soft_reset();
    test_write_protect();
    test_nvram();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/multicart_mapper.md
MULTICART_MAPPER -- requirements
Module: multicart_mapper

Interface
REQ-001 SHALL have parameter NUM_WIN, default 4, number of independent 8K cartridge windows (blk1, blk2, blk3, blk5 at index 0..3); legal 1..4.
REQ-002 SHALL have parameter BANK_W, default 8, bank-number width per window; legal 7..14.
REQ-003 SHALL have parameter RST_CYCLES, default 32, soft-reset pulse length in clk cycles; legal 2..255.
REQ-004 SHALL have parameter BOOT_BANK, default all-ones, bank each window maps to while the mapper is in boot mode.
REQ-005 SHALL have port clk, input, 1, the single system clock.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 Ports: active in 1 (mapper enabled); vic_strobe in 1 (one-cycle CPU access qualifier); vic_addr in 16; vic_wr_n in 1; vic_io2_sel, vic_io3_sel, vic_ram123_sel in 1 each; vic_win_sel in NUM_WIN (one-hot); from_vic in 8.
REQ-008 Ports: to_vic out 8; mc_qm out 1; mc_addr out BANK_W+15 ({2-bit region tag, BANK_W bank, 13-bit offset}); mc_wr_n out 1; mc_sdram_en out 1; mc_soft_reset out 1; mc_busy out 1; mc_nvram_sel out 1; nvram_dirty out 1; nvram_dirty_clr in 1.

Function
REQ-009 Register writes SHALL occur only on vic_strobe & vic_io3_sel & !vic_wr_n; one write per strobe.
REQ-010 Register map (io3, vic_addr[7:0]): 2i = bank[7:0] of window i; 2i+1 = control i (bit7 RAM select, bit6 write-protect, bits[BANK_W-9:0] bank high bits); 0xF0 = global (bit0 nvram enable); 0xFF = reset trigger.
REQ-011 Each window SHALL hold a shadow and a live copy; writes update shadow always, live also when bank_ena=1.
REQ-012 While bank_ena=0 (boot mode), every window SHALL map ROM bank BOOT_BANK, RAM select and write-protect ignored.
REQ-013 Writing 0xA5 to 0xFF in IDLE SHALL start the reset sequence; any other value, or any write while mc_busy=1, SHALL be ignored.
REQ-014 Sequence FSM: IDLE -> PULSE (mc_soft_reset=1 exactly RST_CYCLES cycles, down-counter) -> COMMIT (one cycle: shadow copied to live, bank_ena set to 1) -> IDLE; mc_busy=1 in PULSE and COMMIT.
REQ-015 Register writes arriving during PULSE or COMMIT SHALL be dropped.
REQ-016 Reads of offsets 2i, 2i+1, 0xF0 under vic_strobe & vic_io3_sel & vic_wr_n SHALL return shadow values on to_vic with mc_qm=1 the following cycle; mc_qm=0 otherwise; unmapped offsets give mc_qm=0.
REQ-017 Selected window i SHALL drive mc_addr tag 01 (ROM) or 10 (cart RAM) with live bank and vic_addr[12:0]; no window selected: tag 00, bank 0, vic_addr passthrough in low 16 bits.
REQ-018 mc_wr_n SHALL be forced high for ROM windows and for RAM windows with write-protect set; when active=0 all outputs pass vic_* through unmodified, tag 00.
REQ-019 Window index wraparound: offsets for i >= NUM_WIN SHALL be unmapped (write ignored, read mc_qm=0).

Reset
REQ-020 reset_n low SHALL asynchronously force: FSM IDLE, counter 0, bank_ena 0, all shadow/live registers 0, nvram enable 0, nvram_dirty 0, to_vic 0, mc_qm 0, mc_soft_reset 0, mc_busy 0.
REQ-021 reset_n asserted mid-PULSE SHALL end the pulse immediately with no COMMIT.

Configuration
REQ-022 With MULTICART_NVRAM_EN defined: ram123/io2/io3 accesses with nvram enable=1 SHALL assert mc_nvram_sel and mc_sdram_en, tag 11; a write strobe there SHALL set nvram_dirty; nvram_dirty_clr clears it; simultaneous set and clear: set wins.
REQ-023 Without MULTICART_NVRAM_EN: mc_nvram_sel and nvram_dirty SHALL be constant 0, global bit0 reads 0, mc_sdram_en equals the core's existing enable.

Structure
REQ-024 Package multicart_pkg SHALL hold FSM state enum, region tags, register offsets, and the 0xA5 trigger constant.
REQ-025 The FSM and counter SHALL be sub-module multicart_reset_seq; windows generated by a loop over NUM_WIN.

Verification
REQ-026 After reset, access blk5 (window 3) -> mc_addr tag 01, bank BOOT_BANK, offset vic_addr[12:0].
REQ-027 Write window0 bank 0x12 in boot mode, then 0xA5 to 0xFF -> mc_soft_reset high exactly 32 cycles, COMMIT, window0 maps bank 0x12.
REQ-028 Write 0x5A to 0xFF -> no pulse; write 0xA5 during PULSE -> pulse length unchanged, second trigger ignored.
REQ-029 Window1 control 0xC0 after commit, write to 0x4000 -> mc_wr_n high, tag 10; control 0x80 -> write passes.
REQ-030 With MULTICART_NVRAM_EN, nvram enable=1, write 0x0400 together with nvram_dirty_clr -> nvram_dirty=1; reset_n low mid-PULSE -> mc_soft_reset 0 same cycle, bank_ena 0.
